lstm_gate_mac: RTL

- Gate pre-activation engine that sits directly upstream of the gate memory.
- Consumes the 16-lane x/wx and h/wh word streams and the bias word produced by the memory sequencer.
- Forms b + Σ(x·wx) + Σ(h·wh) per neuron, saturates the sum, and applies a hard activation.
- Emits one gate value per neuron with a gate-memory write address. Neurons 0–63 = i, 64–127 = f, 128–191 = g, 192–255 = o.

---
 rtl/lstm_gate_mac.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lstm_gate_mac.sv
// Gate pre-activation engine: 16-lane MAC pipeline, saturating accumulator and
// hard sigmoid/tanh activation, emitting one addressed gate value per neuron.
module lstm_gate_mac #(
   parameter int WL    = 16,
   parameter int FRAC  = 12,
   parameter int LANES = 16,
   parameter int ACC_W = 2*WL+8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vec_valid,
   input  logic                  first,
   input  logic                  last,
   input  logic [WL-1:0]         b,
   input  logic [LANES*WL-1:0]   a_vec,
   input  logic [LANES*WL-1:0]   w_vec,
   output logic [WL-1:0]         gate_out,
   output logic                  gate_valid,
   output logic [7:0]            gate_addr,
   output logic                  done
);

   localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (WL-1)) - 1);
   localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;
   localparam logic signed [WL+1:0]    ONE  = (WL+2)'(1 << FRAC);
   localparam logic signed [WL+1:0]    HALF = (WL+2)'(1 << (FRAC-1));

   logic signed [2*WL-1:0] prod_q [LANES];
   logic                   v1_q, first1_q, last1_q;
   logic [WL-1:0]          b1_q;

   logic signed [ACC_W-1:0] tree_d, tree_q;
   logic                    v2_q, first2_q, last2_q;
   logic [WL-1:0]           b2_q;

   logic signed [ACC_W-1:0] acc_d, acc_q;
   logic                    pend_q;

   logic signed [ACC_W-1:0] s_full;
   logic signed [WL+1:0]    s_ext, sig_t, y_d;
   logic [WL-1:0]           gate_q;
   logic                    gv_q, done_q;
   logic [7:0]              addr_q, cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
         b1_q     <= '0;
         for (int unsigned k = 0; k < LANES; k++) prod_q[k] <= '0;
      end else begin
         v1_q     <= vec_valid;
         first1_q <= vec_valid & first;
         last1_q  <= vec_valid & last;
         b1_q     <= b;
         for (int unsigned k = 0; k < LANES; k++)
            prod_q[k] <= $signed(a_vec[k*WL +: WL]) * $signed(w_vec[k*WL +: WL]);
      end
   end

   always_comb begin
      tree_d = '0;
      for (int unsigned k = 0; k < LANES; k++)
         tree_d = tree_d + ACC_W'(prod_q[k]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tree_q   <= '0;
         v2_q     <= 1'b0;
         first2_q <= 1'b0;
         last2_q  <= 1'b0;
         b2_q     <= '0;
      end else begin
         tree_q   <= tree_d;
         v2_q     <= v1_q;
         first2_q <= first1_q;
         last2_q  <= last1_q;
         b2_q     <= b1_q;
      end
   end

   // Bias is pre-scaled into the product domain (FRAC*2 fractional bits).
   always_comb begin
      acc_d = acc_q;
      if (v2_q) begin
         if (first2_q) acc_d = (ACC_W'($signed(b2_q)) <<< FRAC) + tree_q;
         else          acc_d = acc_q + tree_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         pend_q <= v2_q & last2_q;
      end
   end

   always_comb begin
      s_full = acc_q >>> FRAC;
      if (s_full > SMAX)      s_ext = (WL+2)'(SMAX);
      else if (s_full < SMIN) s_ext = (WL+2)'(SMIN);
      else                    s_ext = (WL+2)'(s_full);
      sig_t = (s_ext >>> 2) + HALF;
      y_d   = '0;
      if (cnt_q[7:6] == 2'b10) begin
         if (s_ext > ONE)       y_d = ONE;
         else if (s_ext < -ONE) y_d = -ONE;
         else                   y_d = s_ext;
      end else begin
         if (sig_t > ONE)       y_d = ONE;
         else if (sig_t < 0)    y_d = '0;
         else                   y_d = sig_t;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gate_q <= '0;
         gv_q   <= 1'b0;
         addr_q <= '0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         gv_q   <= pend_q;
         done_q <= 1'b0;
         if (pend_q) begin
            gate_q <= y_d[WL-1:0];
            addr_q <= cnt_q;
            done_q <= (cnt_q == 8'd255);
            cnt_q  <= cnt_q + 8'd1;
         end
      end
   end

   assign gate_out   = gate_q;
   assign gate_valid = gv_q;
   assign gate_addr  = addr_q;
   assign done       = done_q;

endmodule
